// File: rtl/os_pkg.sv
// Shared definitions for the output-stationary psum drain.
//   drain_state_t : FSM encoding (IDLE -> DRAIN -> DONE -> IDLE)
//   idx_width()   : element-index width for an n-element array (at least 1 bit)
//   relu_zero()   : true when a psum must be clamped to zero by ReLU
package os_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A negative two's-complement psum becomes zero when ReLU is enabled.
    function automatic logic relu_zero(input logic sign_bit, input logic relu_en);
        return relu_en & sign_bit;
    endfunction

endpackage

// File: rtl/os_psum_lane_sel.sv
// Selects one psum from the captured array snapshot for a given order index.
// Ports:
//   snapshot  : captured array, psum (r,c) at [(r*col+c)*psum_bw +: psum_bw]
//   elem      : order index e of this lane
//   col_major : 0 -> r = e / col, c = e % col; 1 -> c = e / row, r = e % row
//   relu_en   : clamp negative psums to zero
//   psum      : selected (and optionally clamped) psum
module os_psum_lane_sel
    import os_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8,
    localparam int IDX_BW = idx_width(row * col)
) (
    input  logic [psum_bw*col*row-1:0] snapshot,
    input  logic [IDX_BW-1:0]          elem,
    input  logic                       col_major,
    input  logic                       relu_en,
    output logic [psum_bw-1:0]         psum
);

    localparam int N = row * col;

    logic        [psum_bw-1:0] elems [N];
    logic        [IDX_BW-1:0]  flat;
    logic signed [psum_bw-1:0] sel;
    int                        e;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elems[i] = snapshot[i*psum_bw +: psum_bw];
        end
    end

    // Row-major order already equals the storage order; column-major
    // transposes the index into r*col + c.
    always_comb begin
        e    = int'(elem);
        flat = elem;
        if (col_major) begin
            flat = IDX_BW'((e % row) * col + (e / row));
        end
        sel  = elems[flat];
        psum = relu_zero(sel[psum_bw-1], relu_en) ? '0 : sel;
    end

endmodule

// File: rtl/os_psum_drain.sv
// Snapshot-and-serialise drain for the output-stationary MAC array.
// On start (in IDLE) the whole psum array is captured together with the
// ordering and ReLU modes, then streamed out lanes psums per beat over a
// valid/ready handshake.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : capture array and begin drain (ignored outside IDLE)
//   os_out_array  : psum (r,c) at [(r*col+c)*psum_bw +: psum_bw]
//   col_major     : order select, sampled at start
//   relu_en       : ReLU enable, sampled at start
//   out_ready     : consumer accepts beat
//   out_valid     : beat valid
//   out_data      : lane j at [j*psum_bw +: psum_bw]
//   out_idx       : order index of lane 0
//   out_last      : final beat of the drain
//   busy          : high in DRAIN and DONE
//   done          : one-cycle pulse after the last beat is accepted
module os_psum_drain
    import os_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int lanes   = 1,
    localparam int IDX_BW = idx_width(row * col)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [psum_bw*col*row-1:0] os_out_array,
    input  logic                       col_major,
    input  logic                       relu_en,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [psum_bw*lanes-1:0]   out_data,
    output logic [IDX_BW-1:0]          out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int                N      = row * col;
    localparam logic [IDX_BW-1:0] LAST_K = IDX_BW'(N - lanes);
    localparam logic [IDX_BW-1:0] STEP   = IDX_BW'(lanes);

    drain_state_t         state, state_nx;
    logic [IDX_BW-1:0]    k;
    logic [psum_bw*N-1:0] snapshot;
    logic                 col_major_q;
    logic                 relu_q;
    logic                 fire;
    logic                 at_last;

    assign fire    = out_valid & out_ready;
    assign at_last = (k == LAST_K);

    // Capture stage: snapshot, modes and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            k           <= '0;
            snapshot    <= '0;
            col_major_q <= 1'b0;
            relu_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                snapshot    <= os_out_array;
                col_major_q <= col_major;
                relu_q      <= relu_en;
                k           <= '0;
            end else if (fire) begin
                // Return to 0 after the final beat so the next drain starts clean.
                k <= at_last ? '0 : k + STEP;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)          state_nx = ST_DRAIN;
            ST_DRAIN: if (fire & at_last) state_nx = ST_DONE;
            ST_DONE:                      state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid & at_last;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign out_idx   = k;

    // Output stage: purely combinational from registered state
    for (genvar j = 0; j < lanes; j++) begin : g_lane
        logic [IDX_BW-1:0] elem;
        assign elem = k + IDX_BW'(j);

        os_psum_lane_sel #(
            .psum_bw (psum_bw),
            .col     (col),
            .row     (row)
        ) u_sel (
            .snapshot  (snapshot),
            .elem      (elem),
            .col_major (col_major_q),
            .relu_en   (relu_q),
            .psum      (out_data[j*psum_bw +: psum_bw])
        );
    end

endmodule
